// File: rtl/scan_display_decoder_if.sv
// Scan-display decoder bus.
// Groups the multiplexed display inputs and the decoded frame outputs.
//   seg         : segment bus, active-low, seg[6]=a ... seg[0]=g
//   ga          : digit anodes, active-low, ga[3]=digit 3 (leftmost)
//   value       : last complete frame, value[15:12]=digit 3
//   frame_valid : one-cycle pulse when value updates
//   err         : one-cycle pulse on a stable illegal pattern
//   stalled     : watchdog level flag
// master drives the display side; slave is the decoder.
interface scan_display_decoder_if;
  logic [6:0]  seg;
  logic [3:0]  ga;
  logic [15:0] value;
  logic        frame_valid;
  logic        err;
  logic        stalled;

  modport master (
    output seg,
    output ga,
    input  value,
    input  frame_valid,
    input  err,
    input  stalled
  );

  modport slave (
    input  seg,
    input  ga,
    output value,
    output frame_valid,
    output err,
    output stalled
  );
endinterface

// File: rtl/scan_display_decoder.sv
// Scan-display decoder.
// Watches a multiplexed 4-digit 7-segment display (active-low segments and
// anodes), waits for each (seg, ga) pattern to dwell STABLE_CYCLES cycles,
// decodes the digit and assembles a full 4-digit frame starting at digit 3.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : scan_display_decoder_if.slave (seg, ga in; value, frame_valid,
//           err, stalled out)
// Optional feature: define SCAN_TIMEOUT_EN to build the idle watchdog that
// drives stalled; otherwise stalled is tied low.
module scan_display_decoder #(
  parameter int unsigned STABLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input logic                   clk,
  input logic                   rst_n,
  scan_display_decoder_if.slave bus
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] StableMax  = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("scan_display_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {StHunt, StCollect, StEmit} state_e;

  logic [6:0]      r_seg_s1, r_seg_s2;
  logic [3:0]      r_ga_s1, r_ga_s2;
  logic [CntW-1:0] r_cnt;
  state_e          r_state;
  logic [3:0]      r_mask;
  logic [15:0]     r_hold;
  logic [15:0]     r_value;
  logic            r_frame_valid;
  logic            r_err;

  logic            w_same;
  logic            w_capture;
  logic            w_seg_ok;
  logic [3:0]      w_nibble;
  logic            w_blank;
  logic            w_onehot;
  logic [1:0]      w_digit;
  logic            w_valid_cap;
  logic            w_bad_cap;
  logic [3:0]      w_mask_next;

  // Two-flop synchronizer; idles at all ones (display dark).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_ga_s1  <= '1;
      r_ga_s2  <= '1;
    end else begin
      r_seg_s1 <= bus.seg;
      r_seg_s2 <= r_seg_s1;
      r_ga_s1  <= bus.ga;
      r_ga_s2  <= r_ga_s1;
    end
  end

  // Stage 1 is next cycle's stage 2, so comparing them tells whether the
  // sampled pattern is about to change.
  assign w_same    = ({r_seg_s1, r_ga_s1} == {r_seg_s2, r_ga_s2});
  // Fires once per dwell, on the step from STABLE_CYCLES-1 to STABLE_CYCLES.
  assign w_capture = w_same && (r_cnt == StableLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_same) begin
      r_cnt <= '0;
    end else if (r_cnt != StableMax) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_comb begin
    w_seg_ok = 1'b1;
    w_nibble = 4'h0;
    case (r_seg_s2)
      7'h01:   w_nibble = 4'h0;
      7'h4F:   w_nibble = 4'h1;
      7'h12:   w_nibble = 4'h2;
      7'h06:   w_nibble = 4'h3;
      7'h4C:   w_nibble = 4'h4;
      7'h24:   w_nibble = 4'h5;
      7'h20:   w_nibble = 4'h6;
      7'h0F:   w_nibble = 4'h7;
      7'h00:   w_nibble = 4'h8;
      7'h04:   w_nibble = 4'h9;
      7'h08:   w_nibble = 4'hA;
      7'h60:   w_nibble = 4'hB;
      7'h31:   w_nibble = 4'hC;
      7'h42:   w_nibble = 4'hD;
      7'h30:   w_nibble = 4'hE;
      7'h38:   w_nibble = 4'hF;
      default: w_seg_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_blank  = 1'b0;
    w_onehot = 1'b1;
    w_digit  = 2'd0;
    case (r_ga_s2)
      4'b1110: w_digit = 2'd0;
      4'b1101: w_digit = 2'd1;
      4'b1011: w_digit = 2'd2;
      4'b0111: w_digit = 2'd3;
      4'b1111: begin
        w_blank  = 1'b1;
        w_onehot = 1'b0;
      end
      default: w_onehot = 1'b0;
    endcase
  end

  assign w_valid_cap = w_capture && w_onehot && w_seg_ok;
  // Blank periods are silent; everything else that is not a clean digit errs.
  assign w_bad_cap   = w_capture && !w_blank && !(w_onehot && w_seg_ok);
  assign w_mask_next = r_mask | (4'b0001 << w_digit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StHunt;
      r_mask        <= '0;
      r_hold        <= '0;
      r_value       <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_err         <= w_bad_cap;
      case (r_state)
        StHunt: begin
          if (w_valid_cap && (w_digit == 2'd3)) begin
            r_hold[15:12] <= w_nibble;
            r_mask        <= 4'b1000;
            r_state       <= StCollect;
          end
        end
        StCollect: begin
          if (w_valid_cap) begin
            r_hold[{w_digit, 2'b00} +: 4] <= w_nibble;
            r_mask                        <= w_mask_next;
            if (w_mask_next == 4'hF) begin
              r_state <= StEmit;
            end
          end
        end
        StEmit: begin
          r_value       <= r_hold;
          r_frame_valid <= 1'b1;
          r_mask        <= '0;
          r_state       <= StHunt;
        end
        default: r_state <= StHunt;
      endcase
    end
  end

  assign bus.value       = r_value;
  assign bus.frame_valid = r_frame_valid;
  assign bus.err         = r_err;

`ifdef SCAN_TIMEOUT_EN
  logic [31:0] r_idle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_valid_cap) begin
      r_idle <= '0;
    end else if (r_idle != 32'hFFFF_FFFF) begin
      r_idle <= r_idle + 32'd1;
    end
  end

  assign bus.stalled = (r_idle >= 32'(TIMEOUT_CYCLES));
`else
  assign bus.stalled = 1'b0;
`endif

endmodule

// File: tb/tb_scan_display_decoder.sv
// Randomized scoreboard bench for scan_display_decoder.
// The stimulus side describes the input as a list of dwells (pattern, length);
// the reference model turns each long-enough dwell into a capture and pushes
// expected err / frame events (with their cycle) into a queue. A monitor on the
// falling edge pops and compares whenever the DUT pulses an output.
module tb_scan_display_decoder;
  localparam int STABLE_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 100;

  typedef struct {
    int          cyc;
    bit          is_frame;
    logic [15:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  exp_t exp_q[$];
  int   clr_q[$];
  int   last_clear = 0;

  // Reference model state: frame assembly in plain digit terms.
  bit          hunting = 1'b1;
  bit [3:0]    have = 4'h0;
  int          digits[4];
  logic [15:0] model_value = 16'h0;
  logic [10:0] last_pat = '1;

  scan_display_decoder_if ifc ();

  scan_display_decoder #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100; 10: return 7'b0001000; 11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Capture seen at input edge e0 + STABLE; err visible one edge later,
  // frame_valid two edges later.
  task automatic model_capture(input logic [6:0] s, input logic [3:0] g, input int e0);
    int   zeros;
    int   k;
    int   n;
    exp_t ev;
    zeros = 0;
    k = -1;
    n = -1;
    for (int i = 0; i < 4; i++) begin
      if (g[i] == 1'b0) begin
        zeros++;
        k = i;
      end
    end
    if (zeros == 0) return;
    for (int c = 0; c < 16; c++) begin
      if (seg_code(c) == s) n = c;
    end
    if (zeros > 1 || n < 0) begin
      ev.cyc = e0 + STABLE_CYCLES + 1;
      ev.is_frame = 1'b0;
      ev.value = model_value;
      exp_q.push_back(ev);
      return;
    end
    clr_q.push_back(e0 + STABLE_CYCLES + 1);
    if (hunting) begin
      if (k == 3) begin
        digits[3] = n;
        have = 4'b1000;
        hunting = 1'b0;
      end
    end else begin
      digits[k] = n;
      have[k] = 1'b1;
      if (have == 4'hF) begin
        model_value = 16'(digits[3] * 4096 + digits[2] * 256 + digits[1] * 16 + digits[0]);
        ev.cyc = e0 + STABLE_CYCLES + 2;
        ev.is_frame = 1'b1;
        ev.value = model_value;
        exp_q.push_back(ev);
        hunting = 1'b1;
        have = 4'h0;
      end
    end
  endtask

  // Hold one pattern for len cycles; entered and left #1 after a posedge.
  task automatic drive(input logic [6:0] s, input logic [3:0] g, input int len);
    int e0;
    ifc.seg = s;
    ifc.ga = g;
    e0 = cyc + 1;
    if ({s, g} != last_pat && len >= STABLE_CYCLES + 1) model_capture(s, g, e0);
    last_pat = {s, g};
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    int e_r;
    rst_n = 1'b0;
    e_r = cyc + 1;
    @(posedge clk);
    #1;
    check("reset_value", 32'(ifc.value), 32'h0);
    check("reset_frame_valid", 32'(ifc.frame_valid), 32'h0);
    check("reset_err", 32'(ifc.err), 32'h0);
    check("reset_stalled", 32'(ifc.stalled), 32'h0);
    rst_n = 1'b1;
    hunting = 1'b1;
    have = 4'h0;
    model_value = 16'h0;
    clr_q.push_back(e_r);
    last_pat = '1;
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    drive(7'h7F, 4'hF, 4);
    reset_pulse();
    drive(7'h7F, 4'hF, 3);
  endtask

  always @(negedge clk) begin : monitor
    exp_t ev;
    bit   exp_stall;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_%s: got=none by cyc %0d want=pulse at cyc %0d",
                 ev.is_frame ? "frame" : "err", cyc, ev.cyc);
      end
      if (ifc.err || ifc.frame_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got err=%b frame_valid=%b at cyc %0d want=none",
                   ifc.err, ifc.frame_valid, cyc);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.is_frame != ifc.frame_valid || ev.is_frame == ifc.err ||
              ifc.value !== ev.value) begin
            bad++;
            $display("FAIL event_%s: got cyc=%0d fv=%b err=%b value=%h want cyc=%0d value=%h",
                     ev.is_frame ? "frame" : "err", cyc, ifc.frame_valid, ifc.err, ifc.value,
                     ev.cyc, ev.value);
          end
        end
      end
      while (clr_q.size() > 0 && clr_q[0] <= cyc) last_clear = clr_q.pop_front();
`ifdef SCAN_TIMEOUT_EN
      exp_stall = ((cyc - last_clear) >= TIMEOUT_CYCLES);
`else
      exp_stall = 1'b0;
`endif
      total++;
      if (ifc.stalled !== exp_stall) begin
        bad++;
        $display("FAIL stalled: got=%b want=%b at cyc %0d", ifc.stalled, exp_stall, cyc);
      end
    end
  end

  initial begin
    logic [6:0] s;
    logic [3:0] g;
    int         r;
    int         len;
    ifc.seg = '1;
    ifc.ga = '1;
    repeat (3) @(posedge clk);
    #1;
    reset_pulse();
    drive(7'h7F, 4'hF, 3);

    // Straight frame 4,2,9,1.
    drive(7'h4C, 4'b0111, 20);
    drive(7'h12, 4'b1011, 20);
    drive(7'h04, 4'b1101, 20);
    drive(7'h4F, 4'b1110, 20);
    check("frame_4291", 32'(ifc.value), 32'h4291);

    // Start mid-frame: digits 1 and 0 must be ignored while hunting.
    drive(7'h04, 4'b1101, 20);
    drive(7'h4F, 4'b1110, 20);
    drive(7'h4C, 4'b0111, 20);
    drive(7'h12, 4'b1011, 20);
    drive(7'h04, 4'b1101, 20);
    drive(7'h4F, 4'b1110, 20);
    check("frame_midstart", 32'(ifc.value), 32'h4291);

    // Glitching segment bus never dwells long enough.
    for (int i = 0; i < 6; i++) begin
      drive(7'h01, 4'b0111, 3);
      drive(7'h7F, 4'b0111, 3);
    end

    // Two anodes low, then an illegal segment code.
    drive(7'h01, 4'b0011, 20);
    drive(7'h55, 4'b1011, 20);
    check("value_after_err", 32'(ifc.value), 32'h4291);

    // Reset discards a partial frame.
    drive(7'h4C, 4'b0111, 20);
    drive(7'h12, 4'b1011, 20);
    do_reset();
    drive(7'h04, 4'b1101, 20);
    drive(7'h4F, 4'b1110, 20);
    check("value_after_reset", 32'(ifc.value), 32'h0);
    drive(7'h08, 4'b0111, 20);
    drive(7'h60, 4'b1011, 20);
    drive(7'h31, 4'b1101, 20);
    drive(7'h42, 4'b1110, 20);
    check("frame_abcd", 32'(ifc.value), 32'hABCD);

    // Dwell of exactly STABLE_CYCLES is too short; one more cycle captures.
    drive(7'h4F, 4'b0111, STABLE_CYCLES);
    drive(7'h12, 4'b1011, STABLE_CYCLES);
    drive(7'h06, 4'b1101, STABLE_CYCLES);
    drive(7'h4C, 4'b1110, STABLE_CYCLES);
    drive(7'h7F, 4'hF, 3);
    check("short_dwell_no_frame", 32'(ifc.value), 32'hABCD);
    drive(7'h4F, 4'b0111, STABLE_CYCLES + 1);
    drive(7'h12, 4'b1011, STABLE_CYCLES + 1);
    drive(7'h06, 4'b1101, STABLE_CYCLES + 1);
    drive(7'h4C, 4'b1110, STABLE_CYCLES + 1);
    drive(7'h7F, 4'hF, 3);
    check("boundary_dwell_frame", 32'(ifc.value), 32'h1234);

`ifdef SCAN_TIMEOUT_EN
    drive(7'h7F, 4'hF, 120);
    check("stalled_after_idle", 32'(ifc.stalled), 32'h1);
    drive(7'h0F, 4'b0111, STABLE_CYCLES + 1);
    check("stalled_at_capture", 32'(ifc.stalled), 32'h1);
    @(posedge clk);
    #1;
    check("stalled_cleared", 32'(ifc.stalled), 32'h0);
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      do begin
        r = int'($urandom_range(0, 99));
        if (r < 70) g = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 80) g = 4'hF;
        else g = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < 80) s = seg_code(int'($urandom_range(0, 15)));
        else s = 7'($urandom_range(0, 127));
      end while ({s, g} == last_pat);
      if ($urandom_range(0, 99) < 25) len = int'($urandom_range(1, STABLE_CYCLES));
      else len = int'($urandom_range(STABLE_CYCLES + 1, 20));
      drive(s, g, len);
    end

    drive(7'h7F, 4'hF, 30);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
